// File: rtl/sort_checker.sv
// Ordering checker for a CPU result array: counts cycles until the halt PC, then
// reads COUNT words from memory and reports whether they are ordered.
module sort_checker #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int unsigned HALT_PC    = 92,
  parameter int unsigned BASE_ADDR  = 512,
  parameter int unsigned COUNT      = 12,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned DESCENDING = 0,
  parameter int unsigned STRICT     = 1,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       fail_index,
  output logic [31:0]       cycle_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [ADDR_W-1:0] HALT_W  = ADDR_W'(HALT_PC);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       LAST    = (COUNT > 1) ? 16'(COUNT - 1) : 16'd0;
  localparam logic [31:0]       TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
  localparam bit                TO_EN   = (TIMEOUT != 0);

  logic [1:0]        state;
  logic [15:0]       idx;
  logic [15:0]       idx_inc;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] cur;
  logic [31:0]       tcnt;
  logic [ADDR_W-1:0] next_addr;
  logic              lt;
  logic              eq;
  logic              ok;

  assign idx_inc   = idx + 16'd1;
  assign next_addr = BASE_W + (ADDR_W'(idx_inc) << 2);

  // Order test between the previous and the freshly captured element.
  always_comb begin
    eq = (prev == cur);
    if (SIGNED != 0) lt = ($signed(prev) < $signed(cur));
    else             lt = (prev < cur);
    if (DESCENDING != 0) ok = (STRICT != 0) ? (!lt && !eq) : !lt;
    else                 ok = (STRICT != 0) ? lt : (lt || eq);
  end

  // req and busy are their own flops so they cannot glitch on state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      prev        <= '0;
      cur         <= '0;
      tcnt        <= '0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_index  <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc == HALT_W) begin
            idx <= '0;
            if (COUNT <= 1) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state       <= RD;
              mem_rd_req  <= 1'b1;
              mem_rd_addr <= BASE_W;
              busy        <= 1'b1;
              tcnt        <= '0;
            end
          end else if (cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end
        RD: begin
          if (mem_rd_valid) begin
            cur        <= mem_rd_data;
            mem_rd_req <= 1'b0;
            state      <= CMP;
          end else if (TO_EN && (tcnt == TO_LAST)) begin
            mem_rd_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
            fail_index <= idx;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        CMP: begin
          if ((idx != 16'd0) && !ok) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_index <= idx;
            state      <= DONE;
          end else if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
            state <= DONE;
          end else begin
            prev        <= cur;
            idx         <= idx_inc;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= next_addr;
            tcnt        <= '0;
            state       <= RD;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker: one default instance for the main scans and
// reset cases, plus small instances covering strictness, signedness, timeout and COUNT=1.
module tb_sort_checker;

  logic        clk_tb;
  logic        rst_a;
  logic        rst_b;
  logic [31:0] pc_a;
  logic [31:0] pc_b;

  logic        req   [7];
  logic [31:0] addr  [7];
  logic        valid [7];
  logic [31:0] data  [7];
  logic        busy  [7];
  logic        done  [7];
  logic        pass  [7];
  logic        tmo   [7];
  logic [15:0] fidx  [7];
  logic [31:0] ccnt  [7];

  logic [31:0] mem_a [12];
  logic [31:0] mem_b [4];
  logic [31:0] mem_c [4];

  int checks;
  int failures;
  int reads_a;
  logic req6_seen;

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  sort_checker u0 (.clk(clk_tb), .rst(rst_a), .pc(pc_a), .mem_rd_req(req[0]), .mem_rd_addr(addr[0]),
    .mem_rd_valid(valid[0]), .mem_rd_data(data[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .timeout(tmo[0]), .fail_index(fidx[0]), .cycle_count(ccnt[0]));
  sort_checker #(.COUNT(4), .STRICT(1)) u1 (.clk(clk_tb), .rst(rst_b), .pc(pc_b), .mem_rd_req(req[1]),
    .mem_rd_addr(addr[1]), .mem_rd_valid(valid[1]), .mem_rd_data(data[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .timeout(tmo[1]), .fail_index(fidx[1]), .cycle_count(ccnt[1]));
  sort_checker #(.COUNT(4), .STRICT(0)) u2 (.clk(clk_tb), .rst(rst_b), .pc(pc_b), .mem_rd_req(req[2]),
    .mem_rd_addr(addr[2]), .mem_rd_valid(valid[2]), .mem_rd_data(data[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .timeout(tmo[2]), .fail_index(fidx[2]), .cycle_count(ccnt[2]));
  sort_checker #(.COUNT(4), .SIGNED(1), .DESCENDING(1)) u3 (.clk(clk_tb), .rst(rst_b), .pc(pc_b),
    .mem_rd_req(req[3]), .mem_rd_addr(addr[3]), .mem_rd_valid(valid[3]), .mem_rd_data(data[3]),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .timeout(tmo[3]), .fail_index(fidx[3]),
    .cycle_count(ccnt[3]));
  sort_checker #(.COUNT(4), .SIGNED(0), .DESCENDING(1)) u4 (.clk(clk_tb), .rst(rst_b), .pc(pc_b),
    .mem_rd_req(req[4]), .mem_rd_addr(addr[4]), .mem_rd_valid(valid[4]), .mem_rd_data(data[4]),
    .busy(busy[4]), .done(done[4]), .pass(pass[4]), .timeout(tmo[4]), .fail_index(fidx[4]),
    .cycle_count(ccnt[4]));
  sort_checker #(.TIMEOUT(4)) u5 (.clk(clk_tb), .rst(rst_b), .pc(pc_b), .mem_rd_req(req[5]),
    .mem_rd_addr(addr[5]), .mem_rd_valid(valid[5]), .mem_rd_data(data[5]), .busy(busy[5]), .done(done[5]),
    .pass(pass[5]), .timeout(tmo[5]), .fail_index(fidx[5]), .cycle_count(ccnt[5]));
  sort_checker #(.COUNT(1)) u6 (.clk(clk_tb), .rst(rst_b), .pc(pc_b), .mem_rd_req(req[6]),
    .mem_rd_addr(addr[6]), .mem_rd_valid(valid[6]), .mem_rd_data(data[6]), .busy(busy[6]), .done(done[6]),
    .pass(pass[6]), .timeout(tmo[6]), .fail_index(fidx[6]), .cycle_count(ccnt[6]));

  function automatic logic [31:0] rd_word(input logic [31:0] a, input int arr);
    logic [31:0] w;
    w = (a - 32'd512) >> 2;
    rd_word = '0;
    if (arr == 0 && w < 32'd12)     rd_word = mem_a[w[3:0]];
    else if (arr == 1 && w < 32'd4) rd_word = mem_b[w[1:0]];
    else if (arr == 2 && w < 32'd4) rd_word = mem_c[w[1:0]];
  endfunction

  // Zero-wait memories; u5 never answers the read of element 3 (byte 524).
  always_comb begin
    for (int n = 0; n < 7; n++) valid[n] = req[n];
    valid[5] = req[5] && (addr[5] != 32'd524);
    data[0] = rd_word(addr[0], 0);
    data[1] = rd_word(addr[1], 1);
    data[2] = rd_word(addr[2], 1);
    data[3] = rd_word(addr[3], 2);
    data[4] = rd_word(addr[4], 2);
    data[5] = rd_word(addr[5], 0);
    data[6] = rd_word(addr[6], 0);
  end

  always @(posedge clk_tb or posedge rst_a) begin
    if (rst_a) reads_a <= 0;
    else if (req[0] && valid[0]) reads_a <= reads_a + 1;
  end

  always @(posedge clk_tb or posedge rst_b) begin
    if (rst_b) req6_seen <= 1'b0;
    else if (req[6]) req6_seen <= 1'b1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit sorted);
    for (int n = 0; n < 12; n++) mem_a[n] = 32'(11 * n);
    if (!sorted) begin
      mem_a[0] = 55; mem_a[1] = 88;  mem_a[2]  = 0;   mem_a[3]  = 22;
      mem_a[4] = 77; mem_a[5] = 11;  mem_a[6]  = 99;  mem_a[7]  = 33;
      mem_a[8] = 110; mem_a[9] = 66; mem_a[10] = 121; mem_a[11] = 44;
    end
  endtask

  task automatic wait_done0(input int budget);
    for (int k = 0; k < budget && done[0] !== 1'b1; k++) begin
      @(posedge clk_tb);
      #1;
    end
    check_output("wait_done", 32'(done[0]), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pc_a = 32'd0;
    pc_b = 32'd0;
    apply_stimulus(1'b1);
    mem_b[0] = 1; mem_b[1] = 2; mem_b[2] = 2; mem_b[3] = 3;
    mem_c[0] = 5; mem_c[1] = 0; mem_c[2] = 32'hFFFF_FFFD; mem_c[3] = 32'hFFFF_FFF9;
    #12;
    check_output("rst_req",   32'(req[0]),  0);
    check_output("rst_busy",  32'(busy[0]), 0);
    check_output("rst_done",  32'(done[0]), 0);
    check_output("rst_pass",  32'(pass[0]), 0);
    check_output("rst_tmo",   32'(tmo[0]),  0);
    check_output("rst_fidx",  32'(fidx[0]), 0);
    check_output("rst_ccnt",  ccnt[0],      0);
    check_output("rst_addr",  addr[0],      0);

    // Small-configuration group: trigger on the first edge after release.
    @(negedge clk_tb);
    pc_b = 32'd92;
    rst_b = 1'b0;
    @(posedge clk_tb); #1;
    check_output("cnt1_done", 32'(done[6]), 1);
    check_output("cnt1_pass", 32'(pass[6]), 1);
    check_output("to_req",    32'(req[5]),  1);
    check_output("to_addr0",  addr[5],      32'd512);
    repeat (9) @(posedge clk_tb);
    #1;
    check_output("to_addr3",    addr[5],      32'd524);
    check_output("to_not_done", 32'(done[5]), 0);
    @(posedge clk_tb); #1;
    check_output("to_done",     32'(done[5]), 1);
    check_output("to_flag",     32'(tmo[5]),  1);
    check_output("to_fidx",     32'(fidx[5]), 3);
    check_output("to_pass",     32'(pass[5]), 0);
    check_output("strict_done", 32'(done[1]), 1);
    check_output("strict_pass", 32'(pass[1]), 0);
    check_output("strict_fidx", 32'(fidx[1]), 2);
    check_output("loose_done",  32'(done[2]), 1);
    check_output("loose_pass",  32'(pass[2]), 1);
    check_output("sdesc_done",  32'(done[3]), 1);
    check_output("sdesc_pass",  32'(pass[3]), 1);
    check_output("udesc_pass",  32'(pass[4]), 0);
    check_output("udesc_fidx",  32'(fidx[4]), 2);
    check_output("udesc_tmo",   32'(tmo[4]),  0);
    check_output("cnt1_noreq",  32'(req6_seen), 0);

    // Sorted array, trigger after 500 counted cycles.
    @(negedge clk_tb);
    rst_a = 1'b0;
    repeat (500) @(posedge clk_tb);
    #1;
    pc_a = 32'd92;
    @(posedge clk_tb); #1;
    check_output("trig_req",  32'(req[0]),  1);
    check_output("trig_busy", 32'(busy[0]), 1);
    check_output("trig_ccnt", ccnt[0],      32'd500);
    repeat (23) @(posedge clk_tb);
    #1;
    check_output("lat_not_done", 32'(done[0]), 0);
    @(posedge clk_tb); #1;
    check_output("lat_done",  32'(done[0]), 1);
    check_output("full_pass", 32'(pass[0]), 1);
    check_output("full_busy", 32'(busy[0]), 0);
    check_output("full_tmo",  32'(tmo[0]),  0);
    check_output("full_fidx", 32'(fidx[0]), 0);
    check_output("full_reads", 32'(reads_a), 12);
    check_output("full_ccnt", ccnt[0],      32'd500);
    repeat (10) @(posedge clk_tb);
    #1;
    check_output("noretrig_req",   32'(req[0]),  0);
    check_output("noretrig_reads", 32'(reads_a), 12);
    check_output("sticky_done",    32'(done[0]), 1);

    // Unsorted array, trigger immediately after release.
    rst_a = 1'b1;
    apply_stimulus(1'b0);
    @(negedge clk_tb);
    rst_a = 1'b0;
    wait_done0(100);
    check_output("uns_pass",  32'(pass[0]), 0);
    check_output("uns_fidx",  32'(fidx[0]), 2);
    check_output("uns_tmo",   32'(tmo[0]),  0);
    check_output("uns_reads", 32'(reads_a), 3);
    check_output("uns_ccnt",  ccnt[0],      0);

    // Reset while element 5 is being read.
    rst_a = 1'b1;
    apply_stimulus(1'b1);
    @(negedge clk_tb);
    rst_a = 1'b0;
    for (int k = 0; k < 100 && !(req[0] === 1'b1 && addr[0] === 32'd532); k++) begin
      @(posedge clk_tb);
      #1;
    end
    check_output("reach_elem5", addr[0], 32'd532);
    #2;
    rst_a = 1'b1;
    #1;
    check_output("async_req",  32'(req[0]),  0);
    check_output("async_busy", 32'(busy[0]), 0);
    check_output("async_done", 32'(done[0]), 0);
    check_output("async_addr", addr[0],      0);
    pc_a = 32'd0;
    @(negedge clk_tb);
    rst_a = 1'b0;
    repeat (30) @(posedge clk_tb);
    #1;
    check_output("norescan_reads", 32'(reads_a), 0);
    check_output("norescan_busy",  32'(busy[0]), 0);
    check_output("norescan_ccnt",  ccnt[0],      32'd30);
    @(negedge clk_tb);
    pc_a = 32'd92;
    wait_done0(100);
    check_output("rescan_pass",  32'(pass[0]), 1);
    check_output("rescan_reads", 32'(reads_a), 12);
    check_output("rescan_ccnt",  ccnt[0],      32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_checker.md
# sort_checker

Synthesizable, parametrised result checker that sits beside `CPU_MultiCycle` on a spare data-memory read port. It watches the program counter for a halt address and counts execution cycles up to that point. On the halt it scans `COUNT` consecutive words of memory and reports whether they are ordered under the configured mode. It replaces bench-only ordering checks with a block usable in simulation and on hardware, adding signed/descending/non-strict modes, latency-tolerant reads, a timeout, failure localisation and a cycle counter.

## Interface
- `ADDR_W`, 32, PC and byte-address width
- `DATA_W`, 32, memory word width
- `HALT_PC`, 92, PC value that triggers the scan
- `BASE_ADDR`, 512, byte address of element 0; word-aligned
- `COUNT`, 12, number of elements; ≥ 0
- `SIGNED`, 0, 1 = two's-complement compare
- `DESCENDING`, 0, 1 = expect non-increasing order
- `STRICT`, 1, 1 = equal neighbours fail
- `TIMEOUT`, 0, max cycles to wait per read; 0 = disabled
- `clk  in  1`  clock; all state updates on the rising edge
- `rst  in  1`  asynchronous, active-high reset
- `pc  in  ADDR_W`  CPU program counter register output
- `mem_rd_req  out  1`  read request
- `mem_rd_addr  out  ADDR_W`  byte address; held while `mem_rd_req` is high
- `mem_rd_valid  in  1`  read data valid
- `mem_rd_data  in  DATA_W`  read data
- `busy  out  1`  scan in progress
- `done  out  1`  sticky; the result is final
- `pass  out  1`  sticky; valid when `done` is high
- `timeout  out  1`  sticky; failure was caused by a read timeout
- `fail_index  out  16`  index of the second element of the first bad pair
- `cycle_count  out  32`  cycles from reset release to trigger; saturating

## Operation
- States: IDLE, RD, CMP, DONE. DONE is terminal until `rst`.
- **IDLE**
  - `cycle_count` increments every cycle and saturates at 0xFFFF_FFFF.
  - When `pc == HALT_PC` is sampled: set `i = 0`.
  - If `COUNT ≤ 1`, go directly to DONE with `pass = 1` and issue no reads; otherwise go to RD.
- **RD**
  - `mem_rd_req = 1`, `mem_rd_addr = BASE_ADDR + 4*i` (modulo 2^ADDR_W).
  - A read completes on a cycle with `mem_rd_req && mem_rd_valid`; `mem_rd_data` is captured as `cur`, then go to CMP.
  - `mem_rd_valid` while `mem_rd_req` is low is ignored.
- **CMP**
  - If `i == 0`: `prev = cur`, `i = 1`, go to RD.
  - Otherwise evaluate `ok`:
    - ascending: `prev < cur` if STRICT, else `prev <= cur`
    - descending: `prev > cur` if STRICT, else `prev >= cur`
    - signedness per `SIGNED`
  - If `!ok`: `fail_index = i`, `pass = 0`, go to DONE.
  - Else if `i == COUNT-1`: `pass = 1`, go to DONE.
  - Else: `prev = cur`, `i = i + 1`, go to RD.
- **Timeout**
  - Counter resets on entry to RD.
  - If `TIMEOUT != 0` and `TIMEOUT` cycles elapse in RD without `valid`: `timeout = 1`, `pass = 0`, `fail_index = i`, go to DONE.
- **Re-trigger**: `pc == HALT_PC` outside IDLE is ignored. The block runs one scan per reset, even if `pc` stays at `HALT_PC`.
- `busy = 1` in RD and CMP.
- **Reset values**: all outputs 0, state IDLE, `mem_rd_addr = 0`.
- **Reset mid-scan**: `mem_rd_req` and `busy` drop asynchronously, all results clear, and the block returns to IDLE.

## Timing
- Trigger sampled at edge t: `mem_rd_req` is high after edge t; it is registered and glitch-free.
- `cycle_count` freezes at the value reached at edge t; the trigger cycle itself is not counted.
- Zero-wait memory (`valid` in the same cycle as `req`): each element costs 2 cycles (RD + CMP).
  - Full pass: `done` rises 2·COUNT cycles after the trigger edge.
- Read latency L cycles: each element costs L+2 cycles.
- `mem_rd_req` is low in CMP, so consecutive requests are separated by at least one idle cycle.
- `done` and the result outputs change on the same edge and stay stable until reset.

## Test plan
- Default parameters, array 0,11,22,…,121 at 512, zero-wait memory, `pc` reaching 92 at cycle 500 → `done` 24 cycles after the trigger edge, `pass = 1`, `cycle_count` matches the trigger cycle (≈500).
- Array 55,88,0,22,77,11,99,33,110,66,121,44 → `pass = 0`, `fail_index = 2`, `timeout = 0`, and exactly 3 reads issued.
- Array 1,2,2,3 with `COUNT = 4`: `STRICT = 1` → `fail_index = 2`; `STRICT = 0` → `pass = 1`.
- `SIGNED = 1`, `DESCENDING = 1`, array 5,0,-3,-7 → `pass = 1`; the same array with `SIGNED = 0` → `fail_index = 2`.
- `TIMEOUT = 4`, memory never asserts `valid` for element 3 → `timeout = 1`, `fail_index = 3`, `done` 4 cycles after entering RD.
- `rst` pulsed during the scan at element 5 → outputs clear immediately and no re-scan follows. A new trigger after reset runs a full scan. `COUNT = 1` → `pass = 1` with no `mem_rd_req`.
